// File: rtl/ifft_ctrl_pkg.sv
// Shared constants, stage-offset helper and types for the SDF IFFT frame sequencer.
package ifft_ctrl_pkg;

  localparam int unsigned NFFT    = 64;
  localparam int unsigned NSTAGES = 6;

  // Enabled-cycle offset of stage s (1-based): each earlier stage adds
  // its feedback buffer depth plus the multiplier and output registers.
  function automatic int unsigned stage_offset(input int unsigned s,
                                               input int unsigned nfft = NFFT);
    int unsigned off;
    off = 0;
    for (int unsigned i = 1; i < s; i++) begin
      off += (nfft >> i) + 2;
    end
    return off;
  endfunction

  localparam int unsigned TOTAL_LAT = stage_offset(NSTAGES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic sof;
  } token_t;

endpackage

// File: rtl/ifft_sdf_sequencer_token_delay_line.sv
// Enabled shift register of {valid, sof} tokens mirroring the datapath latency,
// with a start-of-frame tap at the entry offset of every stage.
module token_delay_line
  import ifft_ctrl_pkg::*;
#(
  parameter int unsigned LEN   = NFFT,
  parameter int unsigned NTAPS = NSTAGES,
  parameter int unsigned DEPTH = stage_offset(NTAPS + 1, LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  token_t           tok_in,
  output token_t           tok_exit,
  output logic [NTAPS-1:0] tap_sof,
  output logic             any_valid
);

  token_t sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
    end else if (en) begin
      sr[0] <= tok_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tok_exit = sr[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | sr[i].valid;
    end
  end

  // Offset 0 is the token entering this cycle; offset d>0 sits in sr[d-1].
  for (genvar s = 0; s < NTAPS; s++) begin : g_tap
    localparam int unsigned OFF = stage_offset(s + 1, LEN);
    if (OFF == 0) begin : g_entry
      assign tap_sof[s] = tok_in.sof;
    end else begin : g_reg
      assign tap_sof[s] = sr[OFF-1].sof;
    end
  end

endmodule

// File: rtl/ifft_sdf_sequencer.sv
// Frame sequencer for the SDF IFFT: handshake, global pipeline enable, per-stage
// start pulses, output framing and zero-padded flush/drain.
module ifft_sdf_sequencer
  import ifft_ctrl_pkg::*;
#(
  parameter int unsigned NFFT    = ifft_ctrl_pkg::NFFT,
  parameter int unsigned NSTAGES = ifft_ctrl_pkg::NSTAGES,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush_req,
  output logic               pipe_en,
  output logic               zero_fill,
  output logic [NSTAGES-1:0] stage_start,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eof,
  output logic [FCNT_W-1:0]  out_frame_cnt,
  output logic               busy,
  output logic               flush_done
);

  localparam int unsigned IDX_W = $clog2(NFFT);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   in_idx, out_idx;
  token_t             tok_in, tok_exit;
  logic [NSTAGES-1:0] tap_sof;
  logic               any_valid;
  logic               accepted;

  token_delay_line #(
    .LEN   (NFFT),
    .NTAPS (NSTAGES)
  ) u_tdl (
    .clk       (clk),
    .rst       (rst),
    .en        (pipe_en),
    .tok_in    (tok_in),
    .tok_exit  (tok_exit),
    .tap_sof   (tap_sof),
    .any_valid (any_valid)
  );

  assign accepted = in_valid & in_ready;

  always_comb begin
    state_nx   = state;
    pipe_en    = 1'b0;
    zero_fill  = 1'b0;
    flush_done = 1'b0;
    tok_in     = '0;
    unique case (state)
      IDLE: begin
        if (accepted) begin
          pipe_en      = 1'b1;
          tok_in.valid = 1'b1;
          tok_in.sof   = (in_idx == '0);
          state_nx     = RUN;
        end
      end
      RUN: begin
        // A flush request wins over a beat offered in the same cycle.
        if (flush_req) begin
          state_nx = FLUSH;
        end else if (accepted) begin
          pipe_en      = 1'b1;
          tok_in.valid = 1'b1;
          tok_in.sof   = (in_idx == '0);
        end
      end
      FLUSH: begin
        pipe_en      = 1'b1;
        zero_fill    = 1'b1;
        tok_in.valid = (in_idx != '0);
        if ((in_idx == '0) && !any_valid) begin
          state_nx   = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid   = pipe_en & tok_exit.valid;
  assign out_sof     = out_valid & tok_exit.sof;
  assign out_eof     = out_valid & (out_idx == IDX_W'(NFFT - 1));
  assign stage_start = tap_sof & {NSTAGES{pipe_en}};
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      in_idx        <= '0;
      out_idx       <= '0;
      out_frame_cnt <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != FLUSH);
      if (pipe_en && tok_in.valid) begin
        in_idx <= in_idx + IDX_W'(1);
      end
      if (out_valid) begin
        out_idx <= out_idx + IDX_W'(1);
      end
      if (out_eof) begin
        out_frame_cnt <= out_frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifft_sdf_sequencer.sv
// Directed bench for ifft_sdf_sequencer: framing latency, gaps, back-to-back
// frames, padded flush, flush/valid collision and mid-frame reset.
module tb_ifft_sdf_sequencer;

  localparam int NST = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           flush_req;
  logic           pipe_en;
  logic           zero_fill;
  logic [NST-1:0] stage_start;
  logic           out_valid;
  logic           out_sof;
  logic           out_eof;
  logic [15:0]    out_frame_cnt;
  logic           busy;
  logic           flush_done;

  always #5 clk = ~clk;

  ifft_sdf_sequencer #(
    .NFFT    (64),
    .NSTAGES (NST),
    .FCNT_W  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush_req     (flush_req),
    .pipe_en       (pipe_en),
    .zero_fill     (zero_fill),
    .stage_start   (stage_start),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_frame_cnt (out_frame_cnt),
    .busy          (busy),
    .flush_done    (flush_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int exp_off [NST] = '{0, 34, 52, 62, 68, 72};

  // Monitor state (enabled-cycle and wall-cycle bookkeeping)
  int cyc, en_idx, run, max_run;
  int ss_first [NST];
  int sof_first, sof_cyc, sof_cnt, eof_first, eof_cyc, eof_cnt, ov_cnt;
  int zf_cnt, zf_start, fd_cyc, fd_cnt, rdy_in_flush, acc_cnt, pe_mis, gap_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic mon_clear();
    cyc = 0; en_idx = 0; run = 0; max_run = 0;
    for (int s = 0; s < NST; s++) ss_first[s] = -1;
    sof_first = -1; sof_cyc = -1; sof_cnt = 0;
    eof_first = -1; eof_cyc = -1; eof_cnt = 0; ov_cnt = 0;
    zf_cnt = 0; zf_start = -1; fd_cyc = -1; fd_cnt = 0;
    rdy_in_flush = 0; acc_cnt = 0; pe_mis = 0; gap_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (!zero_fill && (pipe_en !== (in_valid & in_ready & ~flush_req))) pe_mis++;
      if (pipe_en && !zero_fill) acc_cnt++;
      if (!pipe_en) gap_cnt++;
      for (int s = 0; s < NST; s++)
        if (stage_start[s] && ss_first[s] < 0) ss_first[s] = en_idx;
      if (out_valid) ov_cnt++;
      if (out_sof) begin
        sof_cnt++;
        if (sof_first < 0) begin sof_first = en_idx; sof_cyc = cyc; end
      end
      if (out_eof) begin
        eof_cnt++;
        if (eof_first < 0) begin eof_first = en_idx; eof_cyc = cyc; end
      end
      if (pipe_en) begin
        if (out_valid) begin
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
      if (zero_fill) begin
        zf_cnt++;
        if (zf_start < 0) zf_start = cyc;
        if (in_ready) rdy_in_flush++;
      end
      if (flush_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (pipe_en) en_idx++;
      cyc++;
    end
  end

  task automatic drive(input logic v, input logic f);
    in_valid  = v;
    flush_req = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int n, input bit gaps);
    int k;
    int sent;
    k = 0;
    sent = 0;
    while (sent < n) begin
      if (gaps && (k % 3 == 2)) drive(1'b0, 1'b0);
      else begin
        drive(1'b1, 1'b0);
        sent++;
      end
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_clear();
  endtask

  task automatic check_stage_starts(input string pfx);
    for (int s = 0; s < NST; s++)
      check($sformatf("%s_stage_start%0d", pfx, s), ss_first[s], exp_off[s]);
  endtask

  task automatic wait_flush_done(input logic v);
    for (int i = 0; i < 400 && fd_cnt == 0; i++) drive(v, 1'b0);
    check("flush_done_seen", fd_cnt, 1);
  endtask

  initial begin
    // Reset state, with a beat offered during reset
    rst = 1'b1; in_valid = 1'b1; flush_req = 1'b0;
    mon_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_pipe_en", pipe_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", out_frame_cnt, 0);
    check("rst_stage_start", stage_start, 0);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("ready_before_clk", in_ready, 0);
    @(posedge clk); #1;
    check("ready_after_clk", in_ready, 1);
    mon_clear();

    // Contiguous frame (plus following beats to keep the pipe moving)
    send_beats(140, 1'b0);
    check_stage_starts("t1");
    check("t1_sof_first", sof_first, 75);
    check("t1_eof_first", eof_first, 138);
    check("t1_frame_cnt", out_frame_cnt, 1);
    check("t1_busy", busy, 1);
    check("t1_pe_track", pe_mis, 0);

    // Same traffic with every third cycle idle
    do_reset();
    send_beats(140, 1'b1);
    check_stage_starts("t2");
    check("t2_sof_first", sof_first, 75);
    check("t2_eof_first", eof_first, 138);
    check("t2_sof_wall", sof_cyc, 112);
    check("t2_eof_wall", eof_cyc, 207);
    check("t2_gaps", gap_cnt, 69);
    check("t2_pe_track", pe_mis, 0);
    check("t2_frame_cnt", out_frame_cnt, 1);

    // Three back-to-back frames then flush
    do_reset();
    send_beats(192, 1'b0);
    drive(1'b0, 1'b1);
    wait_flush_done(1'b0);
    check("t3_max_run", max_run, 192);
    check("t3_out_valid_cnt", ov_cnt, 192);
    check("t3_sof_cnt", sof_cnt, 3);
    check("t3_eof_cnt", eof_cnt, 3);
    check("t3_frame_cnt", out_frame_cnt, 3);
    check("t3_flush_len", fd_cyc - zf_start, 75);
    check("t3_busy_after", busy, 0);
    check("t3_ready_after", in_ready, 1);

    // Partial frame: flush collides with an offered beat, then padding
    do_reset();
    send_beats(10, 1'b0);
    drive(1'b1, 1'b1);
    wait_flush_done(1'b1);
    drive(1'b0, 1'b0);
    check("t4_accepted", acc_cnt, 10);
    check("t4_pe_track", pe_mis, 0);
    check("t4_zero_fill_cycles", zf_cnt, 130);
    check("t4_flush_len", fd_cyc - zf_start, 129);
    check("t4_out_valid_cnt", ov_cnt, 64);
    check("t4_sof_first", sof_first, 75);
    check("t4_eof_first", eof_first, 138);
    check("t4_eof_cnt", eof_cnt, 1);
    check("t4_frame_cnt", out_frame_cnt, 1);
    check("t4_ready_in_flush", rdy_in_flush, 0);
    check("t4_flush_done_cnt", fd_cnt, 1);
    check("t4_busy_after", busy, 0);

    // Asynchronous reset mid-frame, then a fresh frame
    do_reset();
    send_beats(140, 1'b0);
    #2;
    check("t5_pre_pipe_en", pipe_en, 1);
    check("t5_pre_frame_cnt", out_frame_cnt, 1);
    rst = 1'b1;
    #1;
    check("t5_async_pipe_en", pipe_en, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", in_ready, 0);
    check("t5_async_frame_cnt", out_frame_cnt, 0);
    check("t5_async_stage_start", stage_start, 0);
    check("t5_async_out_valid", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_clear();
    drive(1'b0, 1'b0);
    send_beats(80, 1'b0);
    check_stage_starts("t5");
    check("t5_sof_first", sof_first, 75);
    check("t5_no_flush_done", fd_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
